can_frame_encoder: RTL

CAN_FRAME_ENCODER -- requirements
Module: can_frame_encoder

---
 rtl/can_frame_encoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/can_frame_encoder.sv
// CAN 2.0A (standard identifier) frame encoder.
//
// Serialises one data or remote frame per accepted request. The encoder
// computes the 15-bit CRC and inserts stuff bits. Every field bit, including
// any stuff bit, takes one bit_tick.
//
// Parameters:
//   IFS_BITS  number of recessive intermission bits sent after EOF
//
// Ports:
//   clk       system clock; all state changes happen on its rising edge
//   reset_n   asynchronous active-low reset
//   bit_tick  one-clk pulse per CAN bit time; txd only changes on these cycles
//   start     frame request; accepted only while idle
//   id        11-bit identifier, sent MSB first
//   rtr       remote-frame flag (a remote frame carries no data field)
//   dlc       data length code, sent exactly as latched
//   data      payload; byte 0 is data[63:56]; each byte is sent MSB first
//   txd       serial CAN bit; 1 = recessive
//   busy      a frame is in progress
//   done      one-clk pulse when the frame completes
//   crc       CRC of the current frame, or of the last frame when idle
module can_frame_encoder #(
    parameter int unsigned IFS_BITS = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bit_tick,
    input  logic        start,
    input  logic [10:0] id,
    input  logic        rtr,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output logic [14:0] crc
);

    typedef enum logic [3:0] {
        StIdle, StSof, StId, StRtr, StIde, StR0, StDlc, StData, StCrc,
        StCrcDel, StAck, StAckDel, StEof, StIfs
    } state_e;

    localparam logic [6:0] IfsLast = (IFS_BITS > 0) ? 7'(IFS_BITS - 1) : 7'd0;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;     // bit index within the current field
    logic [2:0]  run_q, run_d;     // length of the current run of equal bits
    logic        last_q, last_d;   // last bit put on the wire
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic [14:0] crc_q, crc_d;
    logic [10:0] id_q, id_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;

    // MSB-first serialisation: shift the field left by the bit index.
    logic [10:0] id_sh;
    logic [3:0]  dlc_sh;
    logic [63:0] data_sh;
    logic [14:0] crc_sh;
    assign id_sh   = id_q << cnt_q;
    assign dlc_sh  = dlc_q << cnt_q;
    assign data_sh = data_q << cnt_q;
    assign crc_sh  = crc_q << cnt_q;

    // Number of data bits: zero for remote frames, and DLC values above 8 mean 8 bytes.
    logic [6:0] n_bits;
    always_comb begin
        if (rtr_q) begin
            n_bits = 7'd0;
        end else if (dlc_q > 4'd8) begin
            n_bits = 7'd64;
        end else begin
            n_bits = {dlc_q, 3'b000};
        end
    end

    logic   tx_bit, fin, stuff_zone, inv;
    state_e nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        last_d  = last_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        crc_d   = crc_q;
        id_d    = id_q;
        rtr_d   = rtr_q;
        dlc_d   = dlc_q;
        data_d  = data_q;
        tx_bit  = 1'b1;
        fin     = 1'b0;
        nxt     = state_q;
        inv     = 1'b0;
        // CrcDel is included so that a stuff bit due after the last CRC bit goes out first.
        stuff_zone = (state_q >= StSof) && (state_q <= StCrcDel);

        if (state_q == StIdle) begin
            if (start) begin
                id_d    = id;
                rtr_d   = rtr;
                dlc_d   = dlc;
                data_d  = data;
                crc_d   = '0;
                cnt_d   = '0;
                run_d   = '0;
                last_d  = 1'b1;  // idle bus is recessive, so SOF starts a new run
                state_d = StSof;
            end
        end else if (bit_tick) begin
            if (stuff_zone && run_q == 3'd5) begin
                // Stuff bit: the complement starts a new run. The CRC and
                // the field counters do not advance.
                txd_d  = ~last_q;
                last_d = ~last_q;
                run_d  = 3'd1;
            end else begin
                unique case (state_q)
                    StSof:    begin tx_bit = 1'b0;       fin = 1'b1;             nxt = StId;     end
                    StId:     begin tx_bit = id_sh[10];  fin = (cnt_q == 7'd10); nxt = StRtr;    end
                    StRtr:    begin tx_bit = rtr_q;      fin = 1'b1;             nxt = StIde;    end
                    StIde:    begin tx_bit = 1'b0;       fin = 1'b1;             nxt = StR0;     end
                    StR0:     begin tx_bit = 1'b0;       fin = 1'b1;             nxt = StDlc;    end
                    StDlc: begin
                        tx_bit = dlc_sh[3];
                        fin    = (cnt_q == 7'd3);
                        nxt    = (n_bits == 7'd0) ? StCrc : StData;
                    end
                    StData: begin
                        tx_bit = data_sh[63];
                        fin    = (cnt_q == n_bits - 7'd1);
                        nxt    = StCrc;
                    end
                    StCrc:    begin tx_bit = crc_sh[14]; fin = (cnt_q == 7'd14); nxt = StCrcDel; end
                    StCrcDel: begin tx_bit = 1'b1;       fin = 1'b1;             nxt = StAck;    end
                    StAck:    begin tx_bit = 1'b1;       fin = 1'b1;             nxt = StAckDel; end
                    StAckDel: begin tx_bit = 1'b1;       fin = 1'b1;             nxt = StEof;    end
                    StEof: begin
                        tx_bit = 1'b1;
                        fin    = (cnt_q == 7'd6);
                        nxt    = (IFS_BITS == 0) ? StIdle : StIfs;
                    end
                    StIfs:    begin tx_bit = 1'b1;       fin = (cnt_q == IfsLast); nxt = StIdle; end
                    default:  begin tx_bit = 1'b1;       fin = 1'b1;             nxt = StIdle;   end
                endcase

                txd_d = tx_bit;

                if (state_q <= StCrc) begin
                    last_d = tx_bit;
                    run_d  = (tx_bit == last_q) ? run_q + 3'd1 : 3'd1;
                end else begin
                    run_d = '0;
                end

                if (state_q <= StData) begin
                    inv   = tx_bit ^ crc_q[14];
                    crc_d = {crc_q[13:0], 1'b0} ^ (inv ? 15'h4599 : 15'h0000);
                end

                if (fin) begin
                    cnt_d   = '0;
                    state_d = nxt;
                    done_d  = (nxt == StIdle);
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            run_q   <= '0;
            last_q  <= 1'b1;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            crc_q   <= '0;
            id_q    <= '0;
            rtr_q   <= 1'b0;
            dlc_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            last_q  <= last_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            crc_q   <= crc_d;
            id_q    <= id_d;
            rtr_q   <= rtr_d;
            dlc_q   <= dlc_d;
            data_q  <= data_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign crc  = crc_q;

endmodule
